// File: rtl/reg_bank.sv
// 8 x DATA_W register bank: one-hot write select, two registered read ports (1-cycle latency),
// optional same-edge write-to-read bypass, sticky malformed-select flag. No backpressure: accepts every cycle.
module reg_bank #(
  parameter int DATA_W   = 16,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [7:0]        destreg_i,
  input  logic [DATA_W-1:0] wrdata_i,
  input  logic              rd_en_i,
  input  logic [2:0]        srcreg_a_i,
  input  logic [2:0]        srcreg_b_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] rddata_a_o,
  output logic [DATA_W-1:0] rddata_b_o,
  output logic              rd_valid_o,
  output logic              wr_err_o
);

  logic [DATA_W-1:0] regs [8];
  logic [2:0]        wr_idx;
  logic              sel_onehot;
  logic              wr_drop;
  logic              wr_do;
  logic              wr_bad;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  always_comb begin
    wr_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (destreg_i[i]) wr_idx = 3'(i);
    end
  end

  assign sel_onehot = $onehot(destreg_i);
  // A write to the hardwired zero register is silently discarded, not an error.
  assign wr_drop    = ZERO_REG && (destreg_i == 8'h01);
  assign wr_do      = wr_en_i && sel_onehot && !wr_drop;
  assign wr_bad     = wr_en_i && !sel_onehot;

  always_comb begin
    rd_a = regs[srcreg_a_i];
    rd_b = regs[srcreg_b_i];
    if (BYPASS && wr_do && (wr_idx == srcreg_a_i)) rd_a = wrdata_i;
    if (BYPASS && wr_do && (wr_idx == srcreg_b_i)) rd_b = wrdata_i;
    if (ZERO_REG && (srcreg_a_i == 3'd0)) rd_a = '0;
    if (ZERO_REG && (srcreg_b_i == 3'd0)) rd_b = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      rddata_a_o <= '0;
      rddata_b_o <= '0;
      rd_valid_o <= 1'b0;
      wr_err_o   <= 1'b0;
    end else begin
      if (wr_do) regs[wr_idx] <= wrdata_i;
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        rddata_a_o <= rd_a;
        rddata_b_o <= rd_b;
      end
      // A new error on the same edge as a clear keeps the flag set.
      if (wr_bad)         wr_err_o <= 1'b1;
      else if (err_clr_i) wr_err_o <= 1'b0;
    end
  end

endmodule
